instruction_fetch_unit: RTL and testbench

- Upstream stage of the single-cycle MIPS controller/datapath: holds the PC, fetches from instruction memory through a ready/request handshake, and presents the instruction and its opCode/funcCode fields to the decoder.
- Computes the next PC from the decoder's Branch code, the ALU zero flag and the rs register value once the datapath commits the instruction.
- Detects syscall (halt) and fetch timeout, and stops in a sticky terminal state for each.

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the single-cycle MIPS core: owns the PC, runs the imem
// request/ready handshake and resolves the next PC when the datapath commits.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic [5:0]  opCode,
    output logic [5:0]  funcCode,
    output logic        instValid,
    input  logic        commit,
    input  logic [1:0]  Branch,
    input  logic        zero,
    input  logic [31:0] rsData,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        halt,
    output logic        fetchErr
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [1:0] BR_SEQ = 2'b00;
    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_JR  = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_q, wait_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] next_pc;
    logic        fetched_syscall;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign fetched_syscall = (imemData[31:26] == 6'd0) && (imemData[5:0] == 6'b001100);

    always_comb begin
        next_pc = pc_plus4;
        case (Branch)
            BR_SEQ:  next_pc = pc_plus4;
            BR_BEQ:  next_pc = zero ? (pc_plus4 + br_offset) : pc_plus4;
            BR_JR:   next_pc = rsData;
            default: next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (imemReady) begin
                    instr_d = imemData;
                    wait_d  = '0;
                    state_d = fetched_syscall ? S_HALT : S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    // A misaligned target (only jr can produce one) leaves pc on the faulting jr.
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = S_ERROR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    assign imemReq     = (state_q == S_FETCH);
    assign imemAddr    = pc_q;
    assign instValid   = (state_q == S_EXEC);
    assign halt        = (state_q == S_HALT);
    assign fetchErr    = (state_q == S_ERROR);
    assign instruction = instr_q;
    assign opCode      = instr_q[31:26];
    assign funcCode    = instr_q[5:0];
    assign pc          = pc_q;
    assign pcPlus4     = pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: inputs change and outputs are
// checked on the falling edge, against hand-computed values.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instruction;
    logic [5:0]  opCode;
    logic [5:0]  funcCode;
    logic        instValid;
    logic        commit;
    logic [1:0]  Branch;
    logic        zero;
    logic [31:0] rsData;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        halt;
    logic        fetchErr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_3000),
        .MAX_WAIT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .instruction(instruction),
        .opCode     (opCode),
        .funcCode   (funcCode),
        .instValid  (instValid),
        .commit     (commit),
        .Branch     (Branch),
        .zero       (zero),
        .rsData     (rsData),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .halt       (halt),
        .fetchErr   (fetchErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        imemReady = 1'b0;
        commit    = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        imemReady = 1'b0;
        imemData  = '0;
        commit    = 1'b0;
        Branch    = 2'b00;
        zero      = 1'b0;
        rsData    = '0;
        step();
        step();

        // Reset state, first request
        check("rst_pc",       pc,          32'h0000_3000);
        check("rst_instr",    instruction, 32'h0);
        check("rst_valid",    {31'd0, instValid}, 32'd0);
        check("rst_halt",     {31'd0, halt},      32'd0);
        check("rst_err",      {31'd0, fetchErr},  32'd0);
        check("rst_req",      {31'd0, imemReq},   32'd1);
        check("rst_addr",     imemAddr,    32'h0000_3000);
        check("rst_pcp4",     pcPlus4,     32'h0000_3004);

        reset     = 1'b0;
        imemReady = 1'b1;
        imemData  = 32'h2508_0001;
        step();
        check("f0_valid",  {31'd0, instValid}, 32'd1);
        check("f0_req",    {31'd0, imemReq},   32'd0);
        check("f0_instr",  instruction, 32'h2508_0001);
        check("f0_op",     {26'd0, opCode},   32'h09);
        check("f0_func",   {26'd0, funcCode}, 32'h01);

        // Sequential commit
        imemReady = 1'b0;
        commit    = 1'b1;
        Branch    = 2'b00;
        step();
        commit = 1'b0;
        check("seq_pc",    pc, 32'h0000_3004);
        check("seq_req",   {31'd0, imemReq},   32'd1);
        check("seq_addr",  imemAddr, 32'h0000_3004);
        check("seq_valid", {31'd0, instValid}, 32'd0);

        // beq imm=-1 taken: target = 0x3008 - 4
        imemReady = 1'b1;
        imemData  = 32'h1000_FFFF;
        step();
        imemReady = 1'b0;
        check("beq_valid", {31'd0, instValid}, 32'd1);
        commit = 1'b1;
        Branch = 2'b01;
        zero   = 1'b1;
        step();
        commit = 1'b0;
        check("beq_t_pc", pc, 32'h0000_3004);

        // beq not taken
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        commit = 1'b1;
        Branch = 2'b01;
        zero   = 1'b0;
        step();
        commit = 1'b0;
        check("beq_nt_pc",  pc,      32'h0000_3008);
        check("beq_nt_p4",  pcPlus4, 32'h0000_300C);

        // j 0x0C10 -> 0x3040
        imemReady = 1'b1;
        imemData  = 32'h0800_0C10;
        step();
        imemReady = 1'b0;
        commit = 1'b1;
        Branch = 2'b11;
        step();
        commit = 1'b0;
        check("j_pc", pc, 32'h0000_3040);

        // jr aligned
        imemReady = 1'b1;
        imemData  = 32'h03E0_0008;
        step();
        imemReady = 1'b0;
        commit = 1'b1;
        Branch = 2'b10;
        rsData = 32'h0000_3100;
        step();
        commit = 1'b0;
        check("jr_pc", pc, 32'h0000_3100);

        // jr misaligned -> sticky error, pc held on the jr
        imemReady = 1'b1;
        step();
        imemReady = 1'b0;
        commit = 1'b1;
        Branch = 2'b10;
        rsData = 32'h0000_3102;
        step();
        check("jrm_err",   {31'd0, fetchErr},  32'd1);
        check("jrm_pc",    pc, 32'h0000_3100);
        check("jrm_req",   {31'd0, imemReq},   32'd0);
        check("jrm_valid", {31'd0, instValid}, 32'd0);
        imemReady = 1'b1;
        step();
        step();
        commit = 1'b0;
        check("jrm_sticky", {31'd0, fetchErr}, 32'd1);
        check("jrm_pc2",    pc, 32'h0000_3100);

        // Timeout: 16 FETCH cycles without ready
        do_reset();
        check("to_clr", {31'd0, fetchErr}, 32'd0);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("to_wait", {31'd0, fetchErr}, 32'd0);
        end
        step();
        check("to_err",  {31'd0, fetchErr}, 32'd1);
        check("to_req",  {31'd0, imemReq},  32'd0);
        check("to_pc",   pc, 32'h0000_3000);

        // Ready arrives in the 15th FETCH cycle
        do_reset();
        for (int i = 1; i <= 14; i++) step();
        imemReady = 1'b1;
        imemData  = 32'h2508_0001;
        step();
        imemReady = 1'b0;
        check("late_valid", {31'd0, instValid}, 32'd1);
        check("late_err",   {31'd0, fetchErr},  32'd0);

        // Syscall -> halt, commit ignored
        do_reset();
        imemReady = 1'b1;
        imemData  = 32'h0000_000C;
        step();
        imemReady = 1'b0;
        check("sys_halt",  {31'd0, halt},      32'd1);
        check("sys_valid", {31'd0, instValid}, 32'd0);
        check("sys_req",   {31'd0, imemReq},   32'd0);
        commit = 1'b1;
        Branch = 2'b00;
        step();
        step();
        commit = 1'b0;
        check("sys_pc",    pc, 32'h0000_3000);
        check("sys_valid2", {31'd0, instValid}, 32'd0);
        check("sys_sticky", {31'd0, halt},      32'd1);

        // Reset in EXEC with simultaneous commit
        do_reset();
        check("rh_halt", {31'd0, halt}, 32'd0);
        imemReady = 1'b1;
        imemData  = 32'h0800_0C10;
        step();
        imemReady = 1'b0;
        check("rx_valid", {31'd0, instValid}, 32'd1);
        reset  = 1'b1;
        commit = 1'b1;
        Branch = 2'b11;
        step();
        reset  = 1'b0;
        commit = 1'b0;
        check("rx_pc",    pc, 32'h0000_3000);
        check("rx_valid0", {31'd0, instValid}, 32'd0);
        check("rx_halt",  {31'd0, halt},      32'd0);
        check("rx_err",   {31'd0, fetchErr},  32'd0);
        check("rx_instr", instruction, 32'h0);
        check("rx_req",   {31'd0, imemReq},   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
